// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 constants and the nonce sequencer state encoding.
package sha256_pkg;
    localparam int BLK_W = 512;
    localparam int DIG_W = 256;
    localparam logic [63:0] LEN_HDR = 64'd640;
    localparam logic [63:0] LEN_DIG = 64'd256;
    localparam logic [DIG_W-1:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    typedef enum logic [2:0] {IDLE, MID, WMID, BLK2, WBLK2, FIN, WFIN, CHECK} state_t;
endpackage

// File: rtl/lz_compare.sv
// lz_compare: hit when the top i_zeros bits of the digest are all zero (counts >= 64 check 64+ bits).
module lz_compare
    import sha256_pkg::*;
(
    input  logic [DIG_W-1:0] i_digest,
    input  logic [6:0]       i_zeros,
    output logic             o_hit
);
    logic [DIG_W-1:0] w_mask;
    assign w_mask = ~({DIG_W{1'b1}} >> i_zeros);
    assign o_hit  = (i_digest & w_mask) == '0;
endmodule

// File: rtl/nonce_sequencer.sv
// nonce_sequencer: drives an external SHA-256 core through double-hash nonce attempts.
// Macro NONCE_SEQ_MIDSTATE_CACHE_EN reuses the first-block midstate across attempts.
module nonce_sequencer
    import sha256_pkg::*;
#(
    parameter int unsigned NONCE_STRIDE = 1,
    parameter int          ZW           = 7
) (
    input  logic              i_clock,
    input  logic              i_resetn,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [639:0]      i_header,
    input  logic [ZW-1:0]     i_zeros,
    output logic              o_core_start,
    output logic [BLK_W-1:0]  o_core_block,
    output logic [DIG_W-1:0]  o_core_hin,
    input  logic              i_core_done,
    input  logic [DIG_W-1:0]  i_core_hout,
    output logic              o_busy,
    output logic              o_found,
    output logic              o_exhausted,
    output logic [31:0]       o_golden_nonce,
    output logic [DIG_W-1:0]  o_hash_out
);
`ifdef NONCE_SEQ_MIDSTATE_CACHE_EN
    localparam state_t MISS_NEXT = BLK2;
`else
    localparam state_t MISS_NEXT = MID;
`endif
    state_t           r_state, w_next;
    logic [639:32]    r_header;
    logic [6:0]       r_zeros;
    logic [31:0]      r_nonce, r_golden, w_nonce_inc;
    logic [DIG_W-1:0] r_mid, r_dig1, r_dig2, r_hash;
    logic [6:0]       w_zeros;
    logic             w_carry, w_hit, w_core_start, w_found, w_exhausted;
    logic             w_is_mid, w_is_blk, w_is_fin;

    assign w_zeros = (32'(i_zeros) > 32'd64) ? 7'd64 : 7'(i_zeros);
    assign {w_carry, w_nonce_inc} = {1'b0, r_nonce} + 33'(NONCE_STRIDE);

    lz_compare u_lz (
        .i_digest (r_dig2),
        .i_zeros  (r_zeros),
        .o_hit    (w_hit)
    );

    // Block and chaining value follow the state pair so they stay stable while the core works.
    assign w_is_mid = (r_state == MID)  || (r_state == WMID);
    assign w_is_blk = (r_state == BLK2) || (r_state == WBLK2);
    assign w_is_fin = (r_state == FIN)  || (r_state == WFIN);
    assign o_core_block = w_is_mid ? r_header[639:128] :
                          w_is_blk ? {r_header[127:32], r_nonce, 1'b1, 319'b0, LEN_HDR} :
                          w_is_fin ? {r_dig1, 1'b1, 191'b0, LEN_DIG} : '0;
    assign o_core_hin   = w_is_blk ? r_mid : (w_is_mid || w_is_fin) ? SHA256_IV : '0;
    assign o_core_start = w_core_start;
    assign o_found      = w_found;
    assign o_exhausted  = w_exhausted;
    assign o_busy       = r_state != IDLE;
    assign o_golden_nonce = r_golden;
    assign o_hash_out   = r_hash;

    always_ff @(posedge i_clock or negedge i_resetn)
        if (!i_resetn) r_state <= IDLE;
        else           r_state <= w_next;

    always_comb begin
        w_next       = r_state;
        w_core_start = 1'b0;
        w_found      = 1'b0;
        w_exhausted  = 1'b0;
        if (r_state == IDLE) begin
            if (i_start) w_next = MID;
        end else if (i_abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                MID:     begin w_core_start = 1'b1; w_next = WMID; end
                WMID:    if (i_core_done) w_next = BLK2;
                BLK2:    begin w_core_start = 1'b1; w_next = WBLK2; end
                WBLK2:   if (i_core_done) w_next = FIN;
                FIN:     begin w_core_start = 1'b1; w_next = WFIN; end
                WFIN:    if (i_core_done) w_next = CHECK;
                CHECK: begin
                    w_found     = w_hit;
                    w_exhausted = !w_hit && w_carry;
                    w_next      = (w_hit || w_carry) ? IDLE : MISS_NEXT;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_resetn)
        if (!i_resetn) begin
            r_header <= '0;
            r_zeros  <= '0;
            r_nonce  <= '0;
            r_mid    <= '0;
            r_dig1   <= '0;
            r_dig2   <= '0;
            r_golden <= '0;
            r_hash   <= '0;
        end else begin
            if (r_state == IDLE && i_start) begin
                r_header <= i_header[639:32];
                r_zeros  <= w_zeros;
                r_nonce  <= i_header[31:0];
                r_golden <= '0;
                r_hash   <= '0;
            end
            if (!i_abort) begin
                if (r_state == WMID  && i_core_done) r_mid  <= i_core_hout;
                if (r_state == WBLK2 && i_core_done) r_dig1 <= i_core_hout;
                if (r_state == WFIN  && i_core_done) r_dig2 <= i_core_hout;
                if (r_state == CHECK && !w_hit)      r_nonce <= w_nonce_inc;
            end
            if (w_found) begin
                r_golden <= r_nonce;
                r_hash   <= r_dig2;
            end
        end
endmodule

// File: tb/tb_nonce_sequencer.sv
// tb_nonce_sequencer: randomized jobs against a behavioural attempt-level model and a stand-in hash core.
module tb_nonce_sequencer;
`ifdef NONCE_SEQ_MIDSTATE_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif
    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    logic clk = 0, rstn = 0, start = 0, abort = 0, core_done = 0;
    logic [639:0] header = '0;
    logic [6:0]   zeros = '0;
    logic [255:0] core_hout = '0;
    logic         core_start, busy, found, exhausted;
    logic [511:0] core_block;
    logic [255:0] core_hin, hash_out;
    logic [31:0]  golden;

    int checks = 0, errors = 0;
    int lat = 3, cnt = 0, n_starts = 0, pulses = 0;
    logic [255:0] pend;
    logic [767:0] exp_q[$];
    int m_jobs, m_att;
    bit m_found, m_exh;
    logic [31:0]  m_nonce;
    logic [255:0] m_hash;

    always #5 clk = ~clk;

    nonce_sequencer dut (
        .i_clock(clk), .i_resetn(rstn), .i_start(start), .i_abort(abort),
        .i_header(header), .i_zeros(zeros),
        .o_core_start(core_start), .o_core_block(core_block), .o_core_hin(core_hin),
        .i_core_done(core_done), .i_core_hout(core_hout),
        .o_busy(busy), .o_found(found), .o_exhausted(exhausted),
        .o_golden_nonce(golden), .o_hash_out(hash_out)
    );

    task automatic chk(input string tag, input logic [767:0] got, input logic [767:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Stand-in compression function: any deterministic mix works since the DUT only routes data.
    function automatic logic [255:0] mix(input logic [511:0] b, input logic [255:0] h);
        logic [31:0] a;
        logic [255:0] r;
        a = 32'h811c9dc5;
        for (int i = 0; i < 16; i++) a = (a ^ b[i*32 +: 32]) * 32'h01000193;
        for (int i = 0; i < 8; i++)  a = (a ^ h[i*32 +: 32]) * 32'h01000193;
        for (int i = 0; i < 8; i++) begin
            a = a ^ (a >> 15);
            a = a * 32'h2c1b3c6d;
            a = a ^ (a >> 12);
            a = a + 32'h9e3779b9;
            r[i*32 +: 32] = a;
        end
        return r;
    endfunction

    function automatic int clz(input logic [255:0] d);
        for (int i = 255; i >= 0; i--) if (d[i]) return 255 - i;
        return 256;
    endfunction

    function automatic logic [639:0] rnd_hdr();
        logic [639:0] h;
        for (int i = 0; i < 20; i++) h[i*32 +: 32] = $urandom;
        return h;
    endfunction

    // Attempt-level reference: queues every expected core job and the job outcome.
    task automatic model(input logic [639:0] h, input int z);
        logic [255:0] mid, d1, d2;
        logic [511:0] blk, fin;
        logic [32:0]  n;
        int zc;
        zc = z > 64 ? 64 : z;
        exp_q.delete();
        m_jobs = 0; m_att = 0; m_found = 0; m_exh = 0; m_nonce = 0; m_hash = 0;
        mid = mix(h[639:128], IV);
        n = {1'b0, h[31:0]};
        while (m_att < 5000) begin
            if (m_att == 0 || !CACHE) begin
                exp_q.push_back({h[639:128], IV});
                m_jobs++;
            end
            blk = {h[127:32], n[31:0], 1'b1, 319'b0, 64'd640};
            d1 = mix(blk, mid);
            fin = {d1, 1'b1, 191'b0, 64'd256};
            d2 = mix(fin, IV);
            exp_q.push_back({blk, mid});
            exp_q.push_back({fin, IV});
            m_jobs += 2;
            m_att++;
            if (clz(d2) >= zc) begin
                m_found = 1; m_nonce = n[31:0]; m_hash = d2;
                break;
            end
            n = {1'b0, n[31:0]} + 33'd1;
            if (n[32]) begin
                m_exh = 1;
                break;
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        core_done = 0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                core_done = 1;
                core_hout = pend;
            end
        end
        if (core_start) begin
            n_starts++;
            pend = mix(core_block, core_hin);
            cnt = lat;
            chk("core_job", {core_block, core_hin}, exp_q.size() > 0 ? exp_q.pop_front() : '0);
        end
    end

    task automatic run(input logic [639:0] h, input int z, input int l);
        int cyc, exp_cyc;
        bit done;
        model(h, z);
        exp_cyc = m_jobs * (l + 1) + m_att;
        lat = l; n_starts = 0; done = 0; cyc = 0;
        @(posedge clk); #1;
        header = h; zeros = 7'(z); start = 1;
        while (!done && cyc < exp_cyc + 20) begin
            @(posedge clk); #1;
            start = (cyc == 2);
            header = rnd_hdr();
            cyc++;
            @(negedge clk);
            if (cyc == 1) chk("cleared", {busy, golden, hash_out}, {1'b1, 288'b0});
            if (found || exhausted) begin
                done = 1;
                chk("pulse_cyc", 768'(cyc), 768'(exp_cyc));
                chk("pulse_kind", {found, exhausted}, {m_found, m_exh});
            end
        end
        if (!done) chk("timeout", 768'(cyc), 768'(exp_cyc));
        @(negedge clk);
        chk("idle_after", {busy, found, exhausted}, 3'b0);
        chk("golden", golden, m_found ? m_nonce : 32'h0);
        chk("hash_out", hash_out, m_found ? m_hash : 256'h0);
        chk("starts", 768'(n_starts), 768'(m_jobs));
        chk("queue_left", 768'(exp_q.size()), 768'(0));
    endtask

    task automatic launch(input logic [639:0] h, input int l, input int nwait);
        model(h, 64);
        lat = l; n_starts = 0; pulses = 0;
        @(posedge clk); #1;
        header = h; zeros = 7'd64; start = 1;
        @(posedge clk); #1;
        start = 0;
        for (int i = 0; i < 200 && n_starts < nwait; i++) @(negedge clk);
    endtask

    initial begin
        logic [639:0] h;
        int z;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", {core_start, busy, found, exhausted, golden, hash_out}, '0);
        chk("rst_core", {core_block, core_hin}, '0);
        @(posedge clk); #1 rstn = 1;

        h = rnd_hdr(); h[31:0] = 32'h5;
        run(h, 0, 10);
        chk("z0_starts", 768'(n_starts), 768'(3));
        chk("z0_nonce", golden, 32'h5);

        for (int t = 0; t < 300; t++) begin
            h = rnd_hdr();
            model(h, 4);
            if (m_found && m_att == 4) break;
        end
        run(h, 4, 2);

        h = rnd_hdr(); h[31:0] = 32'hFFFFFFFF;
        run(h, 64, 3);
        chk("wrap_exh", {found, exhausted, busy}, 3'b0);
        chk("wrap_starts", 768'(n_starts), 768'(3));

        h = rnd_hdr(); h[31:0] = 32'hFFFFFFFC;
        run(h, 64, 2);
        chk("four_att_starts", 768'(n_starts), CACHE ? 768'(9) : 768'(12));

        h = rnd_hdr(); h[31:0] = 32'hFFFFFFFD;
        run(h, 100, 1);

        for (int j = 0; j < 6; j++) begin
            h = rnd_hdr();
            if (j == 2) h[31:0] = 32'hFFFFFFF0 + $urandom_range(0, 15);
            z = $urandom_range(0, 5);
            run(h, z, $urandom_range(1, 5));
        end

        launch(rnd_hdr(), 3, 2);
        @(posedge clk); #1 abort = 1;
        @(posedge clk); #1 abort = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (found || exhausted) pulses++;
            if (i == 0) chk("abort_busy", busy, 1'b0);
        end
        chk("abort_pulses", 768'(pulses), 768'(0));
        chk("abort_starts", 768'(n_starts), 768'(2));
        exp_q.delete();

        launch(rnd_hdr(), 4, 3);
        @(posedge clk); #1 rstn = 0;
        #1;
        chk("rst_async", {core_start, busy, found, exhausted, golden, hash_out}, '0);
        chk("rst_async_core", {core_block, core_hin}, '0);
        @(posedge clk); #1 rstn = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (found || exhausted || busy) pulses++;
        end
        chk("rst_quiet", 768'(pulses), 768'(0));
        chk("rst_starts", 768'(n_starts), 768'(3));
        exp_q.delete();

        h = rnd_hdr();
        run(h, 2, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nonce_sequencer.md
NONCE_SEQUENCER -- requirements
Module: nonce_sequencer

Interface
REQ-001 Parameter NONCE_STRIDE, default 1, nonce increment per attempt (lets N sequencers split the nonce space).
REQ-002 Parameter ZW, default 7, width of the difficulty input.
REQ-003 clock  in  1  sole clock; all state changes on its rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle job start; ignored unless busy=0.
REQ-006 abort  in  1  one-cycle job cancel.
REQ-007 header  in  640  block header; bit 639 is the first bit hashed; header[31:0] is the initial nonce.
REQ-008 zeros  in  ZW  required count of leading zero bits of the final digest; values above 64 treated as 64.
REQ-009 core_start  out  1  one-cycle request to the SHA-256 compression core.
REQ-010 core_block  out  512  message block for the core.
REQ-011 core_hin  out  256  chaining value for the core.
REQ-012 core_done  in  1  one-cycle completion from the core.
REQ-013 core_hout  in  256  core result, valid with core_done.
REQ-014 busy  out  1  job in progress.
REQ-015 found  out  1  one-cycle pulse when a satisfying hash is found.
REQ-016 exhausted  out  1  one-cycle pulse when the nonce space wraps with no hit.
REQ-017 golden_nonce  out  32  winning nonce, held until the next start.
REQ-018 hash_out  out  256  winning final digest, held until the next start.

Function
REQ-019 States: IDLE, MID, WMID, BLK2, WBLK2, FIN, WFIN, CHECK.
REQ-020 On start in IDLE: latch header and zeros, nonce <= header[31:0], clear golden_nonce and hash_out, go to MID.
REQ-021 MID: core_start=1, block = header[639:128], hin = SHA-256 IV; go to WMID.
REQ-022 WMID: on core_done, latch midstate <= core_hout and go to BLK2.
REQ-023 BLK2: core_start=1, block = {header[127:32], nonce, 1'b1, 319'b0, 64'd640}, hin = midstate; go to WBLK2.
REQ-024 WBLK2: on core_done, latch digest1 and go to FIN.
REQ-025 FIN: core_start=1, block = {digest1, 1'b1, 191'b0, 64'd256}, hin = IV; go to WFIN.
REQ-026 WFIN: on core_done, latch digest2 and go to CHECK.
REQ-027 CHECK hit: if the top min(zeros,64) bits of digest2 are zero, pulse found, load golden_nonce=nonce and hash_out=digest2, go to IDLE.
REQ-028 CHECK miss: nonce <= nonce + NONCE_STRIDE (mod 2^32).
REQ-029 CHECK miss without wrap: go to BLK2.
REQ-030 CHECK miss with wrap: if the addition carries out of bit 31, pulse exhausted and go to IDLE.
REQ-031 core_start is asserted exactly one cycle per request; core_block and core_hin hold stable from core_start until core_done.
REQ-032 core_done outside the WMID, WBLK2 and WFIN states is ignored.
REQ-033 abort in any state other than IDLE: go to IDLE next cycle, no found or exhausted pulse, outputs keep their values; a core_done still in flight is ignored.
REQ-034 abort and start in the same cycle while in IDLE: the start wins.
REQ-035 busy = (state != IDLE).
REQ-036 zeros=0 always hits on the first CHECK.
REQ-037 Latency, first attempt: 3 core jobs plus 4 overhead cycles from start to found.
REQ-038 Latency, each later attempt: 2 core jobs plus 3 overhead cycles.

Reset
REQ-039 resetn low: state=IDLE; every output and internal register is 0.
REQ-040 Reset mid-job abandons the job silently; core_done arriving after reset release is ignored.

Configuration
REQ-041 Macro NONCE_SEQ_MIDSTATE_CACHE_EN selects midstate caching.
REQ-042 With NONCE_SEQ_MIDSTATE_CACHE_EN defined: midstate is computed once per job and CHECK miss goes to BLK2.
REQ-043 Without NONCE_SEQ_MIDSTATE_CACHE_EN: CHECK miss goes to MID, so every attempt costs 3 core jobs; the midstate register is still present.

Structure
REQ-044 Shared package sha256_pkg holds the eight IV words, the state enum, the padding length constants 640 and 256, and the 512/256-bit widths.
REQ-045 One sub-module, lz_compare, evaluates the leading-zero check (256-bit digest, 7-bit count, 1-bit hit) combinationally.

Verification
REQ-046 zeros=0, nonce field 0x00000005, behavioural core with 10-cycle latency -> found after 3 core_start pulses; golden_nonce=0x00000005.
REQ-047 Real header with a known winning nonce N, start at N-3, zeros=32 -> exactly 3 misses, then found with golden_nonce=N and hash_out equal to the reference digest.
REQ-048 Nonce field 0xFFFFFFFF, zeros=64 -> one attempt, then an exhausted pulse with found never asserted.
REQ-049 abort asserted in WBLK2, core_done arriving 2 cycles later -> IDLE, busy=0, no found/exhausted pulse, no further core_start.
REQ-050 resetn low during WFIN -> all outputs 0 immediately; a start pulse while busy=1 is ignored, with nonce and header unchanged.
REQ-051 Build without NONCE_SEQ_MIDSTATE_CACHE_EN, zeros=64, 4 attempts -> 12 core_start pulses; with the macro defined -> 9.
